// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the layer-1 writeback sequencer and its packer:
// reset level, layer code, FSM encodings and byte-lane indices.
package wb_ctrl_pkg;

  localparam logic       RST_ENABLE = 1'b0;
  localparam logic [3:0] LAYER1     = 4'd1;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_RUN   = 2'd1,
    WB_DRAIN = 2'd2,
    WB_DONE  = 2'd3
  } wbState_e;

  // Byte-lane indices into the 64-bit packed word, lane 0 is the least significant.
  localparam logic [2:0] BYTE_ONE = 3'd0;
  localparam logic [2:0] BYTE_TWO = 3'd1;
  localparam logic [2:0] BYTE_THR = 3'd2;
  localparam logic [2:0] BYTE_FOU = 3'd3;
  localparam logic [2:0] BYTE_FIV = 3'd4;
  localparam logic [2:0] BYTE_SIX = 3'd5;
  localparam logic [2:0] BYTE_SEV = 3'd6;
  localparam logic [2:0] BYTE_EIG = 3'd7;

endpackage

// File: rtl/wb_ctrl.sv
// Layer-1 writeback sequencer: steers the byte packer one lane per accepted beat
// and issues one BRAM32k write per lane after every eighth byte.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned BASE_A        = 0,
  parameter int unsigned BASE_B        = 32,
  parameter int unsigned WORDS_PER_ROW = 5,
  parameter logic [3:0]  LAYER_ID      = LAYER1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        layer,
  input  logic [7:0]        num_rows,
  input  logic              abort,
  input  logic              sum_valid,
  output logic              sum_ready,
  output logic              pack_en,
  output logic [2:0]        byte_sel,
  output logic              clr_word,
  output logic              we_BRAM32k,
  output logic [ADDR_W-1:0] addr_BRAM32k_1,
  output logic [ADDR_W-1:0] addr_BRAM32k_2,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_A_ADDR = ADDR_W'(BASE_A);
  localparam logic [ADDR_W-1:0] BASE_B_ADDR = ADDR_W'(BASE_B);
  localparam logic [7:0]        LAST_WORD   = 8'(WORDS_PER_ROW - 1);

  wbState_e          state_q;
  logic [2:0]        byteCnt_q;
  logic [2:0]        byteSel_q;
  logic [7:0]        wordCnt_q;
  logic [7:0]        rowCnt_q;
  logic [7:0]        numRows_q;
  logic [ADDR_W-1:0] addrA_q;
  logic [ADDR_W-1:0] addrB_q;
  logic [ADDR_W-1:0] addrA_d;
  logic [ADDR_W-1:0] addrB_d;
  logic [1:0]        pend_q;
  logic              packEn_q;
  logic              err_q;

  logic beatAcc;
  logic byteLast;
  logic lastBeat;
  logic legalStart;
  logic writeNow;
  logic collide;

  assign beatAcc    = sum_valid && (state_q == WB_RUN);
  assign byteLast   = (byteCnt_q == BYTE_EIG);
  assign lastBeat   = beatAcc && byteLast && (wordCnt_q == LAST_WORD)
                      && (rowCnt_q == numRows_q - 8'd1);
  assign legalStart = (layer == LAYER_ID) && (num_rows != 8'd0);
  assign writeNow   = pend_q[1];
  assign addrA_d    = addrA_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign addrB_d    = addrB_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign collide    = writeNow && (addrA_d == BASE_B_ADDR);

  // pend_q[0] marks a byte-7 beat one cycle later; pend_q[1] is the write strobe itself.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q   <= WB_IDLE;
      byteCnt_q <= BYTE_ONE;
      byteSel_q <= BYTE_ONE;
      wordCnt_q <= 8'd0;
      rowCnt_q  <= 8'd0;
      numRows_q <= 8'd0;
      addrA_q   <= BASE_A_ADDR;
      addrB_q   <= BASE_B_ADDR;
      pend_q    <= 2'b00;
      packEn_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (abort) begin
      state_q  <= WB_IDLE;
      pend_q   <= 2'b00;
      packEn_q <= 1'b0;
    end else begin
      packEn_q <= beatAcc;
      pend_q   <= {pend_q[0], beatAcc && byteLast};
      if (beatAcc) begin
        byteSel_q <= byteCnt_q;
        byteCnt_q <= byteCnt_q + 3'd1;
      end
      if (writeNow) begin
        addrA_q <= addrA_d;
        addrB_q <= addrB_d;
        if (wordCnt_q == LAST_WORD) begin
          wordCnt_q <= 8'd0;
          rowCnt_q  <= rowCnt_q + 8'd1;
        end else begin
          wordCnt_q <= wordCnt_q + 8'd1;
        end
        if (collide) err_q <= 1'b1;
      end
      unique case (state_q)
        WB_IDLE: begin
          if (start) begin
            if (legalStart) begin
              state_q   <= WB_RUN;
              byteCnt_q <= BYTE_ONE;
              wordCnt_q <= 8'd0;
              rowCnt_q  <= 8'd0;
              numRows_q <= num_rows;
              addrA_q   <= BASE_A_ADDR;
              addrB_q   <= BASE_B_ADDR;
              err_q     <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WB_RUN: begin
          if (collide) begin
            state_q <= WB_IDLE;
            pend_q  <= 2'b00;
          end else if (lastBeat) begin
            state_q <= WB_DRAIN;
          end
        end
        WB_DRAIN: begin
          if (writeNow) state_q <= collide ? WB_IDLE : WB_DONE;
        end
        WB_DONE: state_q <= WB_IDLE;
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign sum_ready      = (state_q == WB_RUN);
  assign busy           = (state_q == WB_RUN) || (state_q == WB_DRAIN);
  assign done           = (state_q == WB_DONE);
  assign pack_en        = packEn_q;
  assign byte_sel       = byteSel_q;
  assign we_BRAM32k     = pend_q[1];
  assign clr_word       = pend_q[1];
  assign addr_BRAM32k_1 = addrA_q;
  assign addr_BRAM32k_2 = addrB_q;
  assign err            = err_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: default instance plus a second instance whose
// lane-B region starts at word 3 to provoke a region collision.
module tb_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  layer;
  logic [7:0]  numRows;
  logic        abort;
  logic        sumValid;

  logic        sumReady, packEn, clrWord, we, busy, done, err;
  logic [2:0]  byteSel;
  logic [11:0] addr1, addr2;

  logic        cSumReady, cPackEn, cClrWord, cWe, cBusy, cDone, cErr;
  logic [2:0]  cByteSel;
  logic [11:0] cAddr1, cAddr2;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int wrCount;

  always #5 clk = ~clk;

  wb_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .num_rows(numRows),
    .abort(abort), .sum_valid(sumValid), .sum_ready(sumReady), .pack_en(packEn),
    .byte_sel(byteSel), .clr_word(clrWord), .we_BRAM32k(we),
    .addr_BRAM32k_1(addr1), .addr_BRAM32k_2(addr2), .busy(busy), .done(done), .err(err)
  );

  wb_ctrl #(.BASE_B(3)) dutC (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .num_rows(numRows),
    .abort(abort), .sum_valid(sumValid), .sum_ready(cSumReady), .pack_en(cPackEn),
    .byte_sel(cByteSel), .clr_word(cClrWord), .we_BRAM32k(cWe),
    .addr_BRAM32k_1(cAddr1), .addr_BRAM32k_2(cAddr2), .busy(cBusy), .done(cDone), .err(cErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] ly, input logic [7:0] nr,
                               input logic ab, input logic sv);
    start    = st;
    layer    = ly;
    numRows  = nr;
    abort    = ab;
    sumValid = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'd1, 8'd1, 1'b0, 1'b0);
  endtask

  task automatic beatCycle();
    applyStimulus(1'b0, 4'd1, 8'd1, 1'b0, 1'b1);
  endtask

  task automatic checkReset(input string pfx);
    checkOutput({pfx, " sum_ready"}, sumReady, 0);
    checkOutput({pfx, " pack_en"},   packEn,   0);
    checkOutput({pfx, " byte_sel"},  byteSel,  0);
    checkOutput({pfx, " clr_word"},  clrWord,  0);
    checkOutput({pfx, " we"},        we,       0);
    checkOutput({pfx, " addr1"},     addr1,    0);
    checkOutput({pfx, " addr2"},     addr2,    32);
    checkOutput({pfx, " busy"},      busy,     0);
    checkOutput({pfx, " done"},      done,     0);
    checkOutput({pfx, " err"},       err,      0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; layer = 4'd0; numRows = 8'd0; abort = 1'b0; sumValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    rst = 1'b1;
    idleCycle();
    checkReset("post-reset idle");

    // One-row pass, 40 back-to-back beats.
    applyStimulus(1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    checkOutput("p1 busy after start", busy, 1);
    checkOutput("p1 sum_ready after start", sumReady, 1);
    for (int i = 0; i < 40; i++) begin
      beatCycle();
      checkOutput($sformatf("p1 pack_en b%0d", i), packEn, 1);
      checkOutput($sformatf("p1 byte_sel b%0d", i), byteSel, i % 8);
      checkOutput($sformatf("p1 we b%0d", i), we, (i % 8 == 0 && i > 0) ? 1 : 0);
      checkOutput($sformatf("p1 sum_ready b%0d", i), sumReady, (i == 39) ? 0 : 1);
      if (i % 8 == 0 && i > 0) begin
        checkOutput($sformatf("p1 addr1 b%0d", i), addr1, i / 8 - 1);
        checkOutput($sformatf("p1 addr2 b%0d", i), addr2, 32 + i / 8 - 1);
        checkOutput($sformatf("p1 clr_word b%0d", i), clrWord, 1);
      end
    end
    idleCycle();
    checkOutput("p1 last we", we, 1);
    checkOutput("p1 last clr_word", clrWord, 1);
    checkOutput("p1 last addr1", addr1, 4);
    checkOutput("p1 last addr2", addr2, 36);
    checkOutput("p1 busy in drain", busy, 1);
    checkOutput("p1 no early done", done, 0);
    idleCycle();
    checkOutput("p1 done", done, 1);
    checkOutput("p1 busy at done", busy, 0);
    checkOutput("p1 we at done", we, 0);
    checkOutput("p1 final addr1", addr1, 5);
    checkOutput("p1 final addr2", addr2, 37);
    idleCycle();
    checkOutput("p1 done one cycle", done, 0);

    // Two-row pass with one beat every three cycles; one illegal start while busy.
    applyStimulus(1'b1, 4'd1, 8'd2, 1'b0, 1'b0);
    checkOutput("p2 busy after start", busy, 1);
    wrCount = 0;
    for (int i = 0; i < 80; i++) begin
      beatCycle();
      checkOutput($sformatf("p2 pack_en b%0d", i), packEn, 1);
      checkOutput($sformatf("p2 byte_sel b%0d", i), byteSel, i % 8);
      if (i == 20) applyStimulus(1'b1, 4'd3, 8'd1, 1'b0, 1'b0);
      else idleCycle();
      checkOutput($sformatf("p2 gap1 pack_en b%0d", i), packEn, 0);
      checkOutput($sformatf("p2 we b%0d", i), we, (i % 8 == 7) ? 1 : 0);
      if (we === 1'b1) wrCount++;
      if (i % 8 == 7) begin
        checkOutput($sformatf("p2 addr1 b%0d", i), addr1, i / 8);
        checkOutput($sformatf("p2 addr2 b%0d", i), addr2, 32 + i / 8);
      end
      idleCycle();
      checkOutput($sformatf("p2 gap2 pack_en b%0d", i), packEn, 0);
      checkOutput($sformatf("p2 done b%0d", i), done, (i == 79) ? 1 : 0);
    end
    checkOutput("p2 write count", wrCount, 10);
    checkOutput("p2 start while busy ignored", err, 0);
    checkOutput("p2 final addr1", addr1, 10);
    checkOutput("p2 final addr2", addr2, 42);
    idleCycle();
    checkOutput("p2 idle after done", busy, 0);

    // Illegal starts set err; a legal start clears it.
    applyStimulus(1'b1, 4'd3, 8'd1, 1'b0, 1'b0);
    checkOutput("bad layer err", err, 1);
    checkOutput("bad layer busy", busy, 0);
    checkOutput("bad layer sum_ready", sumReady, 0);
    applyStimulus(1'b1, 4'd1, 8'd0, 1'b0, 1'b0);
    checkOutput("zero rows err", err, 1);
    checkOutput("zero rows busy", busy, 0);
    applyStimulus(1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    checkOutput("legal start clears err", err, 0);
    checkOutput("legal start busy", busy, 1);
    applyStimulus(1'b0, 4'd1, 8'd1, 1'b1, 1'b0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort no done", done, 0);
    applyStimulus(1'b1, 4'd1, 8'd1, 1'b1, 1'b0);
    checkOutput("abort beats start", busy, 0);

    // Abort on the byte-7 beat of word 2.
    applyStimulus(1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    wrCount = 0;
    for (int i = 0; i < 23; i++) begin
      beatCycle();
      if (we === 1'b1) wrCount++;
    end
    applyStimulus(1'b0, 4'd1, 8'd1, 1'b1, 1'b1);
    checkOutput("abort7 busy", busy, 0);
    checkOutput("abort7 pack_en", packEn, 0);
    checkOutput("abort7 sum_ready", sumReady, 0);
    for (int k = 0; k < 3; k++) begin
      idleCycle();
      checkOutput($sformatf("abort7 we c%0d", k), we, 0);
      checkOutput($sformatf("abort7 done c%0d", k), done, 0);
    end
    checkOutput("abort7 writes", wrCount, 2);
    checkOutput("abort7 addr1", addr1, 2);
    checkOutput("abort7 addr2", addr2, 34);
    checkOutput("abort7 err", err, 0);

    // Reset in the middle of a pass.
    applyStimulus(1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) beatCycle();
    checkOutput("midrst byte_sel before", byteSel, 4);
    checkOutput("midrst addr1 before", addr1, 1);
    #2;
    rst = 1'b0;
    #1;
    checkReset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    checkOutput("midrst restart busy", busy, 1);
    for (int i = 0; i < 8; i++) beatCycle();
    idleCycle();
    checkOutput("midrst first we", we, 1);
    checkOutput("midrst first addr1", addr1, 0);
    checkOutput("midrst first addr2", addr2, 32);
    applyStimulus(1'b0, 4'd1, 8'd1, 1'b1, 1'b0);

    // Region collision on the BASE_B = 3 instance.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("col rst sum_ready", cSumReady, 0);
    checkOutput("col rst pack_en", cPackEn, 0);
    checkOutput("col rst byte_sel", cByteSel, 0);
    checkOutput("col rst clr_word", cClrWord, 0);
    checkOutput("col rst addr1", cAddr1, 0);
    checkOutput("col rst addr2", cAddr2, 3);
    applyStimulus(1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    wrCount = 0;
    for (int i = 0; i < 24; i++) begin
      beatCycle();
      if (cWe === 1'b1) wrCount++;
    end
    idleCycle();
    checkOutput("col we at addr 2", cWe, 1);
    if (cWe === 1'b1) wrCount++;
    checkOutput("col addr1", cAddr1, 2);
    checkOutput("col addr2", cAddr2, 5);
    checkOutput("col err before", cErr, 0);
    idleCycle();
    checkOutput("col err set", cErr, 1);
    checkOutput("col busy", cBusy, 0);
    checkOutput("col no done", cDone, 0);
    checkOutput("col addr1 after", cAddr1, 3);
    checkOutput("col addr2 after", cAddr2, 6);
    idleCycle();
    checkOutput("col still no done", cDone, 0);
    checkOutput("col no extra we", cWe, 0);
    checkOutput("col write count", wrCount, 3);
    applyStimulus(1'b0, 4'd1, 8'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
